// File: rtl/mem_arbiter_if.sv
// Request/response bundle between N requesters, the arbiter and one shared LSU.
// master: requesters + LSU side (drives requests and beat completions).
// slave: the arbiter (drives acks, responses and the LSU command).
interface mem_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 32,
    parameter int DW   = 32
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_wen;
    logic [NREQ-1:0]    req_ren;
    logic [NREQ-1:0]    req_sign;
    logic [2*NREQ-1:0]  req_mask;
    logic [AW*NREQ-1:0] req_addr;
    logic [DW*NREQ-1:0] req_wdata;
    logic [8*NREQ-1:0]  req_tlen;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    resp_valid;
    logic [DW-1:0]      resp_rdata;
    logic               mem_start;
    logic               mem_wen;
    logic               mem_ren;
    logic               mem_sign;
    logic [1:0]         mem_mask;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [7:0]         mem_tlen;
    logic               mem_ok;
    logic [DW-1:0]      mem_rdata;
    logic               busy;

    modport master (
        output req_valid, req_wen, req_ren, req_sign, req_mask, req_addr,
               req_wdata, req_tlen, mem_ok, mem_rdata,
        input  req_ack, resp_valid, resp_rdata, mem_start, mem_wen, mem_ren,
               mem_sign, mem_mask, mem_addr, mem_wdata, mem_tlen, busy
    );

    modport slave (
        input  req_valid, req_wen, req_ren, req_sign, req_mask, req_addr,
               req_wdata, req_tlen, mem_ok, mem_rdata,
        output req_ack, resp_valid, resp_rdata, mem_start, mem_wen, mem_ren,
               mem_sign, mem_mask, mem_addr, mem_wdata, mem_tlen, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates NREQ requesters onto one LSU port (fixed priority or round-robin), one transaction at a time.
// Latency: req_ack combinational in the arbitration cycle, mem_start next cycle, resp_valid same cycle as mem_ok.
// Backpressure: requesters hold req_valid until req_ack; the grant is locked until the last beat, no preemption.
module mem_arbiter #(
    parameter int NREQ = 2,
    parameter int MODE = 1,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input logic          clock,
    input logic          reset,
    mem_arbiter_if.slave bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    typedef struct packed {
        logic          wen;
        logic          ren;
        logic          sign;
        logic [1:0]    mask;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [7:0]    tlen;
    } cmd_t;

    state_t          state_q;
    state_t          state_d;
    cmd_t            cmd_q;
    cmd_t            sel_cmd;
    logic            sel_noop;
    logic            noop_q;
    logic [IW-1:0]   gnt_q;
    logic [IW-1:0]   rr_q;
    logic [IW-1:0]   gnt_inc;
    logic [IW-1:0]   win_idx;
    logic            win_vld;
    logic [7:0]      cnt_q;
    logic            done;
    logic [NREQ-1:0] ack_d;
    logic [NREQ-1:0] resp_vld_d;
    logic [DW-1:0]   resp_dat_d;
    logic            mem_start_d;

    // Winner search: from index 0 in fixed-priority mode, from the rr pointer (wrapping) in round-robin mode.
    always_comb begin
        int base;
        int idx_i;
        logic [IW-1:0] idx;
        win_vld = 1'b0;
        win_idx = '0;
        base    = (MODE == 1) ? int'(rr_q) : 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_i = (base + k) % NREQ;
            idx   = IW'(idx_i);
            if (!win_vld && bus.req_valid[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
    end

    // Collect the winner's command; wen+ren together is a read, writes are always a single beat.
    always_comb begin
        sel_cmd       = '0;
        sel_cmd.ren   = bus.req_ren[win_idx];
        sel_cmd.wen   = bus.req_wen[win_idx] & ~bus.req_ren[win_idx];
        sel_cmd.sign  = bus.req_sign[win_idx];
        sel_cmd.mask  = bus.req_mask[win_idx*2 +: 2];
        sel_cmd.addr  = bus.req_addr[win_idx*AW +: AW];
        sel_cmd.wdata = bus.req_wdata[win_idx*DW +: DW];
        sel_cmd.tlen  = bus.req_ren[win_idx] ? bus.req_tlen[win_idx*8 +: 8] : 8'd0;
        sel_noop      = ~bus.req_ren[win_idx] & ~bus.req_wen[win_idx];
    end

    // Next round-robin start point: the requester after the one just served.
    always_comb begin
        gnt_inc = (gnt_q == IW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
    end

    // Next state and per-cycle pulses; a no-op command completes in ISSUE without touching the LSU.
    always_comb begin
        state_d     = state_q;
        ack_d       = '0;
        resp_vld_d  = '0;
        resp_dat_d  = '0;
        mem_start_d = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_vld) begin
                    ack_d[win_idx] = 1'b1;
                    state_d        = ISSUE;
                end
            end
            ISSUE: begin
                if (noop_q) begin
                    resp_vld_d[gnt_q] = 1'b1;
                    done              = 1'b1;
                    state_d           = IDLE;
                end else begin
                    mem_start_d = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_ok) begin
                    resp_vld_d[gnt_q] = 1'b1;
                    resp_dat_d        = bus.mem_rdata;
                    if (cnt_q == 8'd0) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch, beat counter and rr pointer; the command clears at transaction end so IDLE outputs read 0.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cmd_q  <= '0;
            noop_q <= 1'b0;
            gnt_q  <= '0;
            rr_q   <= '0;
            cnt_q  <= '0;
        end else begin
            if (state_q == IDLE && win_vld) begin
                gnt_q  <= win_idx;
                noop_q <= sel_noop;
                cmd_q  <= sel_noop ? '0 : sel_cmd;
                cnt_q  <= sel_cmd.tlen;
            end else if (done) begin
                cmd_q  <= '0;
                noop_q <= 1'b0;
                cnt_q  <= '0;
                rr_q   <= gnt_inc;
            end else if (state_q == WAIT && bus.mem_ok) begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    // The ack path is combinational from req_valid, so it is gated to stay quiet while reset is held.
    assign bus.req_ack    = ack_d & {NREQ{reset}};
    assign bus.resp_valid = resp_vld_d;
    assign bus.resp_rdata = resp_dat_d;
    assign bus.mem_start  = mem_start_d;
    assign bus.mem_wen    = cmd_q.wen;
    assign bus.mem_ren    = cmd_q.ren;
    assign bus.mem_sign   = cmd_q.sign;
    assign bus.mem_mask   = cmd_q.mask;
    assign bus.mem_addr   = cmd_q.addr;
    assign bus.mem_wdata  = cmd_q.wdata;
    assign bus.mem_tlen   = cmd_q.tlen;
    assign bus.busy       = (state_q != IDLE);

endmodule
